sa_output_deskew: RTL
=====================

# sa_output_deskew

Output-side collector for the 16x16 systolic array. It captures the 16-bit partial sums leaving the bottom row of PEs, which arrive staggered by one cycle per column, and realigns them into complete result rows. Aligned rows are buffered in a small FIFO and presented on a valid/ready stream. The block also drives the array-wide PE enable so the array stalls instead of overflowing the buffer.

## Interface
- N, 16: number of array columns.
- DW, 16: partial-sum width, equal to the PE `down_o` width.
- DEPTH, 4: output FIFO depth in rows (power of 2, ≥2).
- ROWS, 16: rows per tile; sets the `out_last` spacing.
- clk, input, 1: single clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous clear of delay lines, FIFO, row counter and error flag.
- psum_i, input, N*DW: bottom-row `down_o` values; column j is `psum_i[j*DW +: DW]`.
- psum_vld_i, input, N: per-column valid, travelling with `psum_i` (column j lags column j-1 by 1 enabled cycle).
- array_en_o, output, 1: enable to every PE; also qualifies capture in this block.
- out_valid, output, 1: FIFO head row available.
- out_ready, input, 1: consumer accepts head row.
- out_data, output, N*DW: aligned row; column j is `out_data[j*DW +: DW]`.
- out_last, output, 1: head row is row ROWS-1 of its tile.
- err_o, output, 1: sticky misalignment error.

## Operation
- Column j passes through a delay line of N-1-j stages, each stage holding {vld, data}. Column N-1 has no delay.
- All delay lines shift only when `array_en_o`=1 and hold otherwise, matching the frozen PEs.
- Aligned row, formed from the delay-line outputs:
  - If all N valids are 1 and `array_en_o`=1, the row is pushed into the FIFO with last = (row_cnt == ROWS-1).
  - row_cnt then increments and wraps ROWS-1 -> 0.
- If any but not all N aligned valids are 1 while `array_en_o`=1: `err_o` sets (sticky), nothing is pushed, and row_cnt is unchanged.
- `array_en_o` = (fifo_count != DEPTH). It is combinational from the count register only, with no path from `out_ready`.
- Pop occurs when `out_valid && out_ready`. Push and pop in the same cycle leave the count unchanged.
- A push is impossible when the FIFO is full because `array_en_o`=0 then.
- No arithmetic is performed: data passes bit-exact, with no truncation or sign handling.
- `flush` (priority over push/pop):
  - Clears all stage valids, FIFO count/pointers, row_cnt and `err_o` at the next edge.
  - The stage data registers are cleared as well.
  - Input valids present in the flush cycle are discarded.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `err_o`=0, all stage valids/data=0, row_cnt=0, fifo_count=0.
- Hence `array_en_o`=1 both during and immediately after reset.
- Latency, with `array_en_o` held high:
  - Column N-1 sample presented in cycle t gives `out_valid`=1 in cycle t+1.
  - Column 0 of the same row was presented at t-(N-1).
- Throughput is 1 row/cycle while `out_ready`=1.
- Stall: when the count reaches DEPTH, `array_en_o` drops in that same cycle and the delay lines freeze.
- When a pop lowers the count, `array_en_o` rises in the next cycle and no row is lost or duplicated.
- `out_data`/`out_last` are stable while `out_valid`=1 and `out_ready`=0.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous); buffered rows are lost.

## Test plan
- Staggered feed, `out_ready`=1:
  - Stimulus: rows r=0..15 with column j value = 256*r + j, column j presented at cycle r+j.
  - Required: 16 rows out in order, the first at cycle 16.
  - Required: `out_data` column j = 256*r + j.
  - Required: `out_last` only on r=15; `err_o`=0.
- Backpressure:
  - Stimulus: same stream with `out_ready`=0 for 10 cycles.
  - Required: `array_en_o` falls the cycle the 4th row is pushed.
  - Required: delay lines hold; after `out_ready`=1 all 16 rows arrive intact and in order.
- Misalignment: drop the column 5 valid for row 3 only.
  - Required: `err_o`=1 from the cycle that row reaches alignment, and stays 1.
  - Required: 15 rows output, and row_cnt does not advance for row 3.
- Flush mid-tile: assert `flush` after 6 rows are pushed and 2 popped.
  - Required: next cycle `out_valid`=0, `err_o`=0.
  - Required: a new tile afterwards starts with row_cnt 0, so `out_last` falls on its 16th row.
- Async reset during a stall:
  - Stimulus: pulse `rst_n` low between edges with the FIFO full.
  - Required: `out_valid`=0 and `array_en_o`=1 immediately.
  - Required: a subsequent tile passes the first test's checks.
- Simultaneous push/pop: at count=3, hold `out_ready`=1 while rows stream.
  - Required: the count stays 3, `array_en_o` never drops, and no row is lost.

Source files
------------

// File: rtl/sa_output_deskew_if.sv
// Signals between the systolic array bottom row, the output collector and the
// downstream row consumer.
interface sa_output_deskew_if #(
    parameter int unsigned N  = 16,
    parameter int unsigned DW = 16
);
    logic [N*DW-1:0] psum_i;
    logic [N-1:0]    psum_vld_i;
    logic            array_en_o;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] out_data;
    logic            out_last;
    logic            err_o;

    modport slave (
        input  psum_i, psum_vld_i, out_ready,
        output array_en_o, out_valid, out_data, out_last, err_o
    );

    modport master (
        output psum_i, psum_vld_i, out_ready,
        input  array_en_o, out_valid, out_data, out_last, err_o
    );
endinterface

// File: rtl/sa_output_deskew.sv
// Realigns staggered bottom-row partial sums into full rows, buffers them in a
// small FIFO and stalls the array through array_en_o when the FIFO is full.
module sa_output_deskew #(
    parameter int unsigned N     = 16,
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ROWS  = 16
) (
    input logic               clk,
    input logic               rst_n,
    input logic               flush,
    sa_output_deskew_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [N-1:0]          aln_vld;
    logic [N-1:0][DW-1:0]  aln_data;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [RW-1:0]         row_cnt_q;
    logic                  err_q;
    logic                  en, push, pop, partial, row_last;
    logic [N*DW-1:0]       mem_data [DEPTH];
    logic                  mem_last [DEPTH];

    assign en = (count_q != CW'(DEPTH));

    for (genvar j = 0; j < N; j++) begin : g_col
        if (j == N - 1) begin : g_nodly
            assign aln_vld[j]  = bus.psum_vld_i[j];
            assign aln_data[j] = bus.psum_i[j*DW +: DW];
        end else begin : g_dly
            localparam int unsigned L = N - 1 - j;
            logic [L-1:0]          vld_q;
            logic [L-1:0][DW-1:0]  dat_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    dat_q <= '0;
                end else if (flush) begin
                    vld_q <= '0;
                    dat_q <= '0;
                end else if (en) begin
                    vld_q[0] <= bus.psum_vld_i[j];
                    dat_q[0] <= bus.psum_i[j*DW +: DW];
                    for (int unsigned k = 1; k < L; k++) begin
                        vld_q[k] <= vld_q[k-1];
                        dat_q[k] <= dat_q[k-1];
                    end
                end
            end

            assign aln_vld[j]  = vld_q[L-1];
            assign aln_data[j] = dat_q[L-1];
        end
    end

    assign row_last = (row_cnt_q == RW'(ROWS - 1));
    assign push     = en & (&aln_vld) & ~flush;
    assign partial  = en & (|aln_vld) & ~(&aln_vld);
    assign pop      = (count_q != '0) & bus.out_ready & ~flush;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            row_cnt_q <= '0;
            err_q     <= 1'b0;
        end else if (flush) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            row_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + PW'(1);
                row_cnt_q <= row_last ? '0 : row_cnt_q + RW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (partial) err_q <= 1'b1;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= aln_data;
            mem_last[wr_ptr_q] <= row_last;
        end
    end

    assign bus.array_en_o = en;
    assign bus.out_valid  = (count_q != '0);
    assign bus.out_data   = bus.out_valid ? mem_data[rd_ptr_q] : '0;
    assign bus.out_last   = bus.out_valid & mem_last[rd_ptr_q];
    assign bus.err_o      = err_q;
endmodule
